// File: rtl/basilisk_memory_unit.sv
// basilisk_memory_unit: scalar load/store responder issuing word requests and packaging in-order load writebacks
module basilisk_memory_unit #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OFFSET_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [4:0]              cmd_dest_reg_addr,
  input  logic [OFFSET_WIDTH-1:0] cmd_dest_offset_addr,
  input  logic [31:0]             cmd_a,
  input  logic                    cmd_op,
  input  logic [31:0]             cmd_mem_base_addr,
  input  logic [31:0]             cmd_mem_offset_addr,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  output logic [3:0]              mem_req_write_enable,
  output logic [31:0]             mem_req_data,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [31:0]             mem_resp_data,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [4:0]              wb_dest_reg_addr,
  output logic [OFFSET_WIDTH-1:0] wb_dest_offset_addr,
  output logic [31:0]             wb_result,
  output logic                    idle
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] FULL = MAX_OUTSTANDING[PW:0];
  logic [PW:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0] tag_reg [MAX_OUTSTANDING];
  logic [OFFSET_WIDTH-1:0] tag_off [MAX_OUTSTANDING];
  logic [31:0] sum;
  logic cmd_fire, push, pop;
  assign sum = cmd_mem_base_addr + cmd_mem_offset_addr;
  assign cmd_ready = (!mem_req_valid || mem_req_ready) && (cmd_op || count < FULL);
  assign cmd_fire = cmd_valid && cmd_ready;
  assign push = cmd_fire && !cmd_op;
  assign mem_resp_ready = (!wb_valid || wb_ready) && count != '0;
  assign pop = mem_resp_valid && mem_resp_ready;
  assign idle = !mem_req_valid && count == '0 && !wb_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      mem_req_write_enable <= '0;
      mem_req_data <= '0;
      wb_valid <= 1'b0;
      wb_dest_reg_addr <= '0;
      wb_dest_offset_addr <= '0;
      wb_result <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (cmd_fire) begin
        mem_req_valid <= 1'b1;
        mem_req_addr <= {sum[31:2], 2'b00};
        mem_req_write_enable <= cmd_op ? 4'hF : 4'h0;
        mem_req_data <= cmd_op ? cmd_a : 32'h0;
      end else if (mem_req_ready) mem_req_valid <= 1'b0;
      if (push) begin
        tag_reg[wr_ptr] <= cmd_dest_reg_addr;
        tag_off[wr_ptr] <= cmd_dest_offset_addr;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        wb_dest_reg_addr <= tag_reg[rd_ptr];
        wb_dest_offset_addr <= tag_off[rd_ptr];
        wb_result <= mem_resp_data;
      end
      wb_valid <= pop ? 1'b1 : (wb_ready ? 1'b0 : wb_valid);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(mem_resp_valid && count == '0));
endmodule

// File: tb/tb_basilisk_memory_unit.sv
// tb_basilisk_memory_unit: randomized scoreboard bench with a word-memory reference model
module tb_basilisk_memory_unit;
  localparam int MAXO = 4;
  localparam int OW = 3;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_op = 0;
  logic [4:0] cmd_dest_reg_addr = 0;
  logic [OW-1:0] cmd_dest_offset_addr = 0;
  logic [31:0] cmd_a = 0, cmd_mem_base_addr = 0, cmd_mem_offset_addr = 0;
  logic mem_req_valid, mem_req_ready = 0;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [3:0] mem_req_write_enable;
  logic mem_resp_valid = 0, mem_resp_ready;
  logic [31:0] mem_resp_data = 0;
  logic wb_valid, wb_ready = 1, idle;
  logic [4:0] wb_dest_reg_addr;
  logic [OW-1:0] wb_dest_offset_addr;
  logic [31:0] wb_result;

  always #5 clk = ~clk;

  basilisk_memory_unit #(.MAX_OUTSTANDING(MAXO), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest_reg_addr(cmd_dest_reg_addr), .cmd_dest_offset_addr(cmd_dest_offset_addr),
    .cmd_a(cmd_a), .cmd_op(cmd_op), .cmd_mem_base_addr(cmd_mem_base_addr),
    .cmd_mem_offset_addr(cmd_mem_offset_addr), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_write_enable(mem_req_write_enable), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dest_reg_addr(wb_dest_reg_addr), .wb_dest_offset_addr(wb_dest_offset_addr),
    .wb_result(wb_result), .idle(idle)
  );

  typedef struct {logic [31:0] addr; logic [3:0] we; logic [31:0] data;} req_t;
  typedef struct {logic [4:0] r; logic [OW-1:0] o; logic [31:0] d;} wb_t;
  typedef struct {logic [31:0] d; int t;} pend_t;
  req_t exp_req[$];
  wb_t exp_wb[$];
  pend_t pend[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  int compared = 0, mismatched = 0, cyc = 0, outs = 0;
  int req_p = 100, wb_p = 100, lat_min = 1, lat_max = 3;
  bit resp_en = 1;
  int wb_cnt = 0, wb_first = 0, wb_last = 0, t;
  bit hold_req = 0, hold_wb = 0, resp_hs = 0;
  req_t er, pr;
  wb_t ew, pw;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic accept();
    logic [31:0] a;
    a = (cmd_mem_base_addr + cmd_mem_offset_addr) & 32'hFFFF_FFFC;
    if (cmd_op) begin
      exp_req.push_back('{a, 4'hF, cmd_a});
      ref_mem[a] = cmd_a;
    end else begin
      exp_req.push_back('{a, 4'h0, 32'h0});
      exp_wb.push_back('{cmd_dest_reg_addr, cmd_dest_offset_addr,
                         ref_mem.exists(a) ? ref_mem[a] : init_word(a)});
      outs++;
    end
  endtask

  task automatic drive(bit op, logic [4:0] r, logic [OW-1:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] f);
    cmd_op = op; cmd_dest_reg_addr = r; cmd_dest_offset_addr = o;
    cmd_a = a; cmd_mem_base_addr = b; cmd_mem_offset_addr = f; cmd_valid = 1;
  endtask

  task automatic complete();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (cmd_ready) accept(); else check("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic issue(bit op, logic [4:0] r, logic [OW-1:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] f);
    drive(op, r, o, a, b, f);
    complete();
  endtask

  task automatic drain(string name);
    int n = 0;
    while (!(idle && exp_req.size() == 0 && exp_wb.size() == 0) && n < 500) begin @(negedge clk); n++; end
    check({name, "_idle"}, idle, 1);
    check({name, "_left"}, exp_wb.size() + exp_req.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; cmd_valid = 0; cmd_op = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_req.delete(); exp_wb.delete(); outs = 0; rst = 0;
  endtask

  // memory model and output monitor share one process so bookkeeping order is fixed
  initial forever begin
    @(posedge clk); cyc++; #1;
    mem_req_ready = $urandom_range(99) < req_p;
    wb_ready = $urandom_range(99) < wb_p;
    mem_resp_valid = !rst && resp_en && pend.size() > 0 && pend[0].t <= cyc;
    mem_resp_data = mem_resp_valid ? pend[0].d : 32'h0;
    @(negedge clk);
    if (rst) begin
      pend.delete(); hold_req = 0; hold_wb = 0; resp_hs = 0;
    end else begin
      if (hold_req) begin
        check("req_hold_valid", mem_req_valid, 1);
        check("req_hold_addr", mem_req_addr, pr.addr);
        check("req_hold_we", mem_req_write_enable, pr.we);
        check("req_hold_data", mem_req_data, pr.data);
      end
      if (hold_wb) begin
        check("wb_hold_valid", wb_valid, 1);
        check("wb_hold_reg", wb_dest_reg_addr, pw.r);
        check("wb_hold_off", wb_dest_offset_addr, pw.o);
        check("wb_hold_result", wb_result, pw.d);
      end
      if (resp_hs) check("wb_latency", wb_valid, 1);
      check("resp_ready_empty", mem_resp_ready && outs == 0, 0);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) check("req_unexpected", 1, 0);
        else begin
          er = exp_req.pop_front();
          check("req_addr", mem_req_addr, er.addr);
          check("req_we", mem_req_write_enable, er.we);
          check("req_data", mem_req_data, er.data);
        end
        if (mem_req_write_enable == 4'hF) dev_mem[mem_req_addr] = mem_req_data;
        else begin
          t = cyc + int'($urandom_range(lat_max, lat_min));
          if (pend.size() > 0 && pend[$].t > t) t = pend[$].t;
          pend.push_back('{dev_mem.exists(mem_req_addr) ? dev_mem[mem_req_addr] : init_word(mem_req_addr), t});
        end
      end
      if (wb_valid && wb_ready) begin
        if (exp_wb.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          ew = exp_wb.pop_front();
          check("wb_reg", wb_dest_reg_addr, ew.r);
          check("wb_off", wb_dest_offset_addr, ew.o);
          check("wb_result", wb_result, ew.d);
        end
        if (wb_cnt == 0) wb_first = cyc;
        wb_cnt++; wb_last = cyc;
      end
      if (mem_resp_valid && mem_resp_ready && pend.size() > 0) begin pend.pop_front(); outs--; end
      hold_req = mem_req_valid && !mem_req_ready;
      pr = '{mem_req_addr, mem_req_write_enable, mem_req_data};
      hold_wb = wb_valid && !wb_ready;
      pw = '{wb_dest_reg_addr, wb_dest_offset_addr, wb_result};
      resp_hs = mem_resp_valid && mem_resp_ready;
    end
  end

  initial begin
    int n;
    do_reset();
    @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_resp_ready", mem_resp_ready, 0);
    @(posedge clk); #1;
    // single load with a known memory word
    dev_mem[32'h1024] = 32'hDEAD_BEEF; ref_mem[32'h1024] = 32'hDEAD_BEEF;
    lat_min = 2; lat_max = 2;
    issue(0, 5'd7, 3'd2, 0, 32'h1000, 32'h24);
    drain("single");
    // store with address wrap
    issue(1, 0, 0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h7);
    drain("store");
    // full tag FIFO
    lat_min = 1; lat_max = 2; resp_en = 0;
    for (int i = 1; i <= 4; i++) issue(0, 5'(i), OW'(i), 0, 32'h2000, 32'(i * 4));
    drive(0, 5'd5, 3'd5, 0, 32'h3000, 0);
    repeat (3) begin @(negedge clk); check("full_refuse", cmd_ready, 0); end
    @(posedge clk); #1;
    drive(1, 0, 0, 32'hCAFE_F00D, 32'h3100, 0);
    @(negedge clk);
    check("full_store", cmd_ready, 1);
    if (cmd_ready) accept();
    @(posedge clk); #1;
    drive(0, 5'd5, 3'd5, 0, 32'h3000, 0);
    resp_en = 1;
    n = 0;
    @(negedge clk);
    while (!(mem_resp_valid && mem_resp_ready) && n < 50) begin @(negedge clk); n++; end
    check("full_pop_refuse", cmd_ready, 0);
    @(negedge clk);
    check("full_release", cmd_ready, 1);
    if (cmd_ready) accept();
    @(posedge clk); #1;
    cmd_valid = 0;
    drain("full");
    // request and writeback backpressure
    req_p = 0;
    @(posedge clk); #1;
    issue(0, 5'd9, 3'd1, 0, 32'h4000, 32'h10);
    drive(1, 0, 0, 32'h55AA_55AA, 32'h4100, 0);
    repeat (3) begin @(negedge clk); check("bp_cmd_ready", cmd_ready, 0); end
    req_p = 100;
    complete();
    drain("bp_req");
    wb_p = 0;
    @(posedge clk); #1;
    issue(0, 5'd10, 3'd2, 0, 32'h4200, 0);
    issue(0, 5'd11, 3'd3, 0, 32'h4204, 0);
    n = 0;
    @(negedge clk);
    while (!(wb_valid && mem_resp_valid) && n < 50) begin @(negedge clk); n++; end
    repeat (3) begin check("bp_resp_ready", mem_resp_ready, 0); @(negedge clk); end
    wb_p = 100;
    drain("bp_wb");
    // streaming at one writeback per cycle
    lat_min = 1; lat_max = 1; wb_cnt = 0;
    for (int i = 0; i < 8; i++) issue(0, 5'(16 + i), OW'(i), 0, 32'h5000, 32'(i * 4));
    drain("stream");
    check("stream_count", wb_cnt, 8);
    check("stream_rate", wb_last - wb_first, 7);
    // randomized mix over a small wrapping address window
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) begin
        req_p = $urandom_range(100, 30); wb_p = $urandom_range(100, 30);
        lat_min = 1; lat_max = $urandom_range(4, 1);
      end
      issue(1'($urandom), 5'($urandom), OW'($urandom), $urandom,
            32'hFFFF_FFF0 + 32'($urandom_range(31)), 32'($urandom_range(31)));
      if ($urandom_range(3) == 0) begin repeat ($urandom_range(3, 1)) @(posedge clk); #1; end
    end
    req_p = 100; wb_p = 100;
    drain("rand");
    // reset with loads outstanding
    resp_en = 0;
    for (int i = 0; i < 3; i++) issue(0, 5'(i + 1), OW'(i), 0, 32'h7000, 32'(i * 4));
    do_reset();
    @(negedge clk);
    check("mrst_idle", idle, 1);
    check("mrst_wb_valid", wb_valid, 0);
    check("mrst_req_valid", mem_req_valid, 0);
    check("mrst_cmd_ready", cmd_ready, 1);
    resp_en = 1;
    @(posedge clk); #1;
    issue(0, 5'd30, 3'd7, 0, 32'h7100, 32'h8);
    drain("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
